frame_bank_sched: RTL and testbench

- Triple-buffer scheduler for the SDRAM frame buffer shared by the camera capture path (write port) and the VGA display path (read port).
- Rotates three frame banks so the writer never overwrites the frame being displayed.
- Drives the write/read start address, max address and LOAD strobes of the 4-port SDRAM controller.
- Counts dropped frames.
- All event inputs are single-cycle pulses already synchronous to iCLK.

---
 rtl/frame_bank_pkg.sv | 19 +
 rtl/load_pulse_gen.sv | 26 ++
 rtl/frame_bank_sched.sv | 157 +++++++++++++++
 tb/tb_frame_bank_sched.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/frame_bank_pkg.sv
// Shared types and helpers for the triple-buffered frame bank scheduler.
package frame_bank_pkg;

  localparam int NUM_BANKS = 3;

  typedef logic [1:0] bank_t;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } sched_state_t;

  // Start address of a bank. Computed at 32 bits; callers truncate to their width.
  function automatic logic [31:0] bank_base(input bank_t idx, input logic [31:0] base,
                                            input logic [31:0] stride);
    return base + ({30'd0, idx} * stride);
  endfunction

endpackage

// File: rtl/load_pulse_gen.sv
// Retriggerable pulse stretcher: output rises the cycle after iTRIG and stays
// high LOAD_CYCLES cycles; a trigger during the pulse restarts the count.
module load_pulse_gen #(
  parameter int LOAD_CYCLES = 4
) (
  input  logic iCLK,
  input  logic iRST_N,
  input  logic iTRIG,
  output logic oPULSE
);

  localparam int CW = $clog2(LOAD_CYCLES + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(LOAD_CYCLES);

  logic [CW-1:0] cnt;

  // Reload on trigger, otherwise count down to idle.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N)        cnt <= '0;
    else if (iTRIG)     cnt <= CNT_INIT;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  end

  assign oPULSE = (cnt != '0);

endmodule

// File: rtl/frame_bank_sched.sv
// Triple-buffer scheduler: rotates three SDRAM frame banks between the capture
// writer and the display reader, drives the controller's address/LOAD pairs and
// counts frames that were overwritten before being displayed.
module frame_bank_sched
  import frame_bank_pkg::*;
#(
  parameter int                ADDR_W      = 22,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 22'h000000,
  parameter logic [ADDR_W-1:0] BANK_STRIDE = 22'h100000,
  parameter int                FRAME_SIZE  = 307200,
  parameter int                LOAD_CYCLES = 4
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iWR_FRAME_START,
  input  logic              iWR_FRAME_END,
  input  logic              iRD_FRAME_START,
  input  logic              iFREEZE,
  output logic [ADDR_W-1:0] oWR_ADDR,
  output logic [ADDR_W-1:0] oWR_MAX_ADDR,
  output logic              oWR_LOAD,
  output logic [ADDR_W-1:0] oRD_ADDR,
  output logic [ADDR_W-1:0] oRD_MAX_ADDR,
  output logic              oRD_LOAD,
  output logic [1:0]        oWR_BANK,
  output logic [1:0]        oRD_BANK,
  output logic [15:0]       oDROP_CNT
);

  localparam int NPORT = 2;  // index 0 = write port, 1 = read port

  function automatic logic [ADDR_W-1:0] addr_of(input bank_t b);
    logic [31:0] full;
    full = bank_base(b, 32'(BASE_ADDR), 32'(BANK_STRIDE));
    return full[ADDR_W-1:0];
  endfunction

  function automatic logic [ADDR_W-1:0] max_of(input bank_t b);
    return addr_of(b) + ADDR_W'(FRAME_SIZE);
  endfunction

  sched_state_t state_q, state_n;
  bank_t        wr_bank, rd_bank, latest;
  bank_t        wr_n, rd_n, latest_n;
  logic         fresh, armed, fresh_n, armed_n;
  logic [15:0]  drop_cnt, drop_n;
  logic         wr_end_v, rd_sw, armed_mid;
  logic [NPORT-1:0]             trig, load;
  logic [NPORT-1:0][ADDR_W-1:0] addr_q, max_q;
  bank_t [NPORT-1:0]            bank_nxt;

  // State register and bank bookkeeping.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q  <= ST_INIT;
      wr_bank  <= 2'd0;
      rd_bank  <= 2'd1;
      latest   <= 2'd1;
      fresh    <= 1'b0;
      armed    <= 1'b0;
      drop_cnt <= '0;
    end else begin
      state_q  <= state_n;
      wr_bank  <= wr_n;
      rd_bank  <= rd_n;
      latest   <= latest_n;
      fresh    <= fresh_n;
      armed    <= armed_n;
      drop_cnt <= drop_n;
    end
  end

  // Event decode: writer END is resolved before START, and a reader switch in
  // the same cycle as a completed frame swaps the two banks directly.
  always_comb begin
    state_n   = state_q;
    wr_n      = wr_bank;
    rd_n      = rd_bank;
    latest_n  = latest;
    fresh_n   = fresh;
    armed_n   = armed;
    drop_n    = drop_cnt;
    trig      = '0;
    wr_end_v  = 1'b0;
    rd_sw     = 1'b0;
    armed_mid = armed;
    case (state_q)
      ST_INIT: begin
        trig    = '1;
        state_n = ST_RUN;
      end
      ST_RUN: begin
        wr_end_v = iWR_FRAME_END & armed;
        rd_sw    = iRD_FRAME_START & ~iFREEZE & (fresh | wr_end_v);
        if (wr_end_v) begin
          if (fresh && drop_cnt != 16'hFFFF) drop_n = drop_cnt + 16'd1;
          latest_n = wr_bank;
          armed_n  = 1'b0;
          trig[0]  = 1'b1;
          if (rd_sw) begin
            rd_n    = wr_bank;
            wr_n    = rd_bank;
            fresh_n = 1'b0;
          end else begin
            wr_n    = bank_t'(NUM_BANKS) - wr_bank - rd_bank;
            fresh_n = 1'b1;
          end
        end else if (rd_sw) begin
          rd_n    = latest;
          fresh_n = 1'b0;
        end
        trig[1]   = rd_sw;
        armed_mid = wr_end_v ? 1'b0 : armed;
        // A second START without END is an aborted frame: restart at bank base.
        if (iWR_FRAME_START) begin
          if (armed_mid) trig[0] = 1'b1;
          else           armed_n = 1'b1;
        end
      end
      default: state_n = ST_INIT;
    endcase
  end

  assign bank_nxt = {rd_n, wr_n};

  // Per-port address registers and LOAD strobe generators.
  for (genvar p = 0; p < NPORT; p++) begin : g_port
    // Addresses follow the next bank so they change on the edge LOAD rises.
    always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
        addr_q[p] <= addr_of(bank_t'(p + 1 == 1 ? 0 : 1));
        max_q[p]  <= max_of(bank_t'(p + 1 == 1 ? 0 : 1));
      end else begin
        addr_q[p] <= addr_of(bank_nxt[p]);
        max_q[p]  <= max_of(bank_nxt[p]);
      end
    end

    load_pulse_gen #(.LOAD_CYCLES(LOAD_CYCLES)) u_load (
      .iCLK  (iCLK),
      .iRST_N(iRST_N),
      .iTRIG (trig[p]),
      .oPULSE(load[p])
    );
  end

  assign oWR_ADDR     = addr_q[0];
  assign oWR_MAX_ADDR = max_q[0];
  assign oWR_LOAD     = load[0];
  assign oRD_ADDR     = addr_q[1];
  assign oRD_MAX_ADDR = max_q[1];
  assign oRD_LOAD     = load[1];
  assign oWR_BANK     = wr_bank;
  assign oRD_BANK     = rd_bank;
  assign oDROP_CNT    = drop_cnt;

endmodule

// File: tb/tb_frame_bank_sched.sv
// Directed bench for frame_bank_sched: drives event pulses on the falling edge
// and samples outputs on falling edges, against hand-computed expectations.
module tb_frame_bank_sched;

  logic        iCLK = 1'b0;
  logic        iRST_N = 1'b1;
  logic        iWR_FRAME_START = 1'b0, iWR_FRAME_END = 1'b0;
  logic        iRD_FRAME_START = 1'b0, iFREEZE = 1'b0;
  logic [21:0] oWR_ADDR, oWR_MAX_ADDR, oRD_ADDR, oRD_MAX_ADDR;
  logic        oWR_LOAD, oRD_LOAD;
  logic [1:0]  oWR_BANK, oRD_BANK;
  logic [15:0] oDROP_CNT;

  int total = 0;
  int bad   = 0;

  frame_bank_sched dut (
    .iCLK(iCLK), .iRST_N(iRST_N),
    .iWR_FRAME_START(iWR_FRAME_START), .iWR_FRAME_END(iWR_FRAME_END),
    .iRD_FRAME_START(iRD_FRAME_START), .iFREEZE(iFREEZE),
    .oWR_ADDR(oWR_ADDR), .oWR_MAX_ADDR(oWR_MAX_ADDR), .oWR_LOAD(oWR_LOAD),
    .oRD_ADDR(oRD_ADDR), .oRD_MAX_ADDR(oRD_MAX_ADDR), .oRD_LOAD(oRD_LOAD),
    .oWR_BANK(oWR_BANK), .oRD_BANK(oRD_BANK), .oDROP_CNT(oDROP_CNT)
  );

  always #5 iCLK = ~iCLK;

  task automatic apply_reset();
    iWR_FRAME_START = 0; iWR_FRAME_END = 0; iRD_FRAME_START = 0; iFREEZE = 0;
    iRST_N = 0;
    repeat (2) @(negedge iCLK);
    iRST_N = 1;
  endtask

  // One-cycle event pulse; starts and ends on a falling edge.
  task automatic ev(input logic ws, input logic we, input logic rs);
    iWR_FRAME_START = ws; iWR_FRAME_END = we; iRD_FRAME_START = rs;
    @(negedge iCLK);
    iWR_FRAME_START = 0; iWR_FRAME_END = 0; iRD_FRAME_START = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge iCLK);
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if ({oWR_ADDR, oWR_MAX_ADDR} !== {22'h000000, 22'h04B000}) begin bad++;
      $display("FAIL reset_wr_addr: got %h/%h want 000000/04b000", oWR_ADDR, oWR_MAX_ADDR); end
    total++; if ({oRD_ADDR, oRD_MAX_ADDR} !== {22'h100000, 22'h14B000}) begin bad++;
      $display("FAIL reset_rd_addr: got %h/%h want 100000/14b000", oRD_ADDR, oRD_MAX_ADDR); end
    total++; if ({oWR_LOAD, oRD_LOAD, oWR_BANK, oRD_BANK, oDROP_CNT} !== {2'b00, 2'd0, 2'd1, 16'd0}) begin bad++;
      $display("FAIL reset_state: load=%b%b wb=%0d rb=%0d drop=%0d want 00 0 1 0",
               oWR_LOAD, oRD_LOAD, oWR_BANK, oRD_BANK, oDROP_CNT); end
    for (int k = 1; k <= 4; k++) begin
      @(negedge iCLK);
      total++; if ({oWR_LOAD, oRD_LOAD} !== 2'b11) begin bad++;
        $display("FAIL init_load_c%0d: got %b%b want 11", k, oWR_LOAD, oRD_LOAD); end
    end
    @(negedge iCLK);
    total++; if ({oWR_LOAD, oRD_LOAD} !== 2'b00) begin bad++;
      $display("FAIL init_load_end: got %b%b want 00", oWR_LOAD, oRD_LOAD); end
  endtask

  task automatic test_basic();
    ev(1, 0, 0);
    total++; if (oWR_LOAD !== 1'b0) begin bad++;
      $display("FAIL start_no_load: got %b want 0", oWR_LOAD); end
    ev(0, 1, 0);
    total++; if ({oWR_BANK, oWR_ADDR, oWR_MAX_ADDR, oWR_LOAD} !== {2'd2, 22'h200000, 22'h24B000, 1'b1}) begin bad++;
      $display("FAIL end_wr: bank=%0d addr=%h max=%h load=%b want 2 200000 24b000 1",
               oWR_BANK, oWR_ADDR, oWR_MAX_ADDR, oWR_LOAD); end
    for (int k = 2; k <= 4; k++) begin
      @(negedge iCLK);
      total++; if (oWR_LOAD !== 1'b1) begin bad++;
        $display("FAIL end_wr_load_c%0d: got %b want 1", k, oWR_LOAD); end
    end
    @(negedge iCLK);
    total++; if (oWR_LOAD !== 1'b0) begin bad++;
      $display("FAIL end_wr_load_off: got %b want 0", oWR_LOAD); end
    ev(0, 0, 1);
    total++; if ({oRD_BANK, oRD_ADDR, oRD_MAX_ADDR, oRD_LOAD, oDROP_CNT} !== {2'd0, 22'h000000, 22'h04B000, 1'b1, 16'd0}) begin bad++;
      $display("FAIL rd_switch: bank=%0d addr=%h max=%h load=%b drop=%0d want 0 000000 04b000 1 0",
               oRD_BANK, oRD_ADDR, oRD_MAX_ADDR, oRD_LOAD, oDROP_CNT); end
    idle(4);
    ev(0, 0, 1);
    total++; if ({oRD_BANK, oRD_LOAD} !== {2'd0, 1'b0}) begin bad++;
      $display("FAIL rd_no_fresh: bank=%0d load=%b want 0 0", oRD_BANK, oRD_LOAD); end
  endtask

  // Three frames, the middle ones using same-cycle END+START.
  task automatic test_drops();
    logic [1:0]  exp_wb [3];
    logic [15:0] exp_dc [3];
    exp_wb = '{2'd2, 2'd0, 2'd2};
    exp_dc = '{16'd0, 16'd1, 16'd2};
    apply_reset(); idle(5);
    ev(1, 0, 0);
    for (int f = 0; f < 3; f++) begin
      ev((f < 2) ? 1'b1 : 1'b0, 1, 0);
      total++; if ({oWR_BANK, oRD_BANK, oDROP_CNT} !== {exp_wb[f], 2'd1, exp_dc[f]}) begin bad++;
        $display("FAIL drop_frame%0d: wb=%0d rb=%0d drop=%0d want %0d 1 %0d",
                 f, oWR_BANK, oRD_BANK, oDROP_CNT, exp_wb[f], exp_dc[f]); end
    end
    // fresh=1, wr=2, rd=1: END+RD_START swaps and still counts the drop.
    ev(1, 0, 0);
    ev(0, 1, 1);
    total++; if ({oWR_BANK, oRD_BANK, oDROP_CNT, oWR_LOAD, oRD_LOAD} !== {2'd1, 2'd2, 16'd3, 2'b11}) begin bad++;
      $display("FAIL swap_fresh: wb=%0d rb=%0d drop=%0d load=%b%b want 1 2 3 11",
               oWR_BANK, oRD_BANK, oDROP_CNT, oWR_LOAD, oRD_LOAD); end
  endtask

  task automatic test_simul();
    apply_reset(); idle(5);
    ev(1, 0, 0);
    ev(0, 1, 1);
    total++; if ({oRD_BANK, oWR_BANK, oWR_LOAD, oRD_LOAD, oDROP_CNT} !== {2'd0, 2'd1, 2'b11, 16'd0}) begin bad++;
      $display("FAIL simul: rb=%0d wb=%0d load=%b%b drop=%0d want 0 1 11 0",
               oRD_BANK, oWR_BANK, oWR_LOAD, oRD_LOAD, oDROP_CNT); end
    total++; if ({oRD_ADDR, oWR_ADDR} !== {22'h000000, 22'h100000}) begin bad++;
      $display("FAIL simul_addr: rd=%h wr=%h want 000000 100000", oRD_ADDR, oWR_ADDR); end
    idle(4);
    ev(0, 0, 1);
    total++; if ({oRD_BANK, oRD_LOAD} !== {2'd0, 1'b0}) begin bad++;
      $display("FAIL simul_fresh_clr: rb=%0d load=%b want 0 0", oRD_BANK, oRD_LOAD); end
  endtask

  // Continues from test_simul: wr=1 rd=0 latest=0 fresh=0 drop=0.
  task automatic test_freeze();
    iFREEZE = 1;
    ev(1, 0, 0); ev(0, 1, 0);
    ev(1, 0, 0); ev(0, 1, 0);
    idle(4);
    ev(0, 0, 1);
    total++; if ({oRD_BANK, oRD_LOAD, oWR_BANK, oDROP_CNT} !== {2'd0, 1'b0, 2'd1, 16'd1}) begin bad++;
      $display("FAIL freeze_hold: rb=%0d rload=%b wb=%0d drop=%0d want 0 0 1 1",
               oRD_BANK, oRD_LOAD, oWR_BANK, oDROP_CNT); end
    iFREEZE = 0;
    ev(0, 0, 1);
    total++; if ({oRD_BANK, oRD_LOAD, oRD_ADDR} !== {2'd2, 1'b1, 22'h200000}) begin bad++;
      $display("FAIL unfreeze: rb=%0d rload=%b addr=%h want 2 1 200000", oRD_BANK, oRD_LOAD, oRD_ADDR); end
  endtask

  // Continues from test_freeze: wr=1 rd=2 fresh=0 armed=0 drop=1.
  task automatic test_abort_reset();
    idle(4);
    ev(1, 0, 0);
    ev(1, 0, 0);
    total++; if ({oWR_BANK, oWR_LOAD, oWR_ADDR} !== {2'd1, 1'b1, 22'h100000}) begin bad++;
      $display("FAIL abort_reload: wb=%0d load=%b addr=%h want 1 1 100000", oWR_BANK, oWR_LOAD, oWR_ADDR); end
    @(negedge iCLK);
    ev(1, 0, 0);
    for (int k = 2; k <= 4; k++) begin
      @(negedge iCLK);
      total++; if (oWR_LOAD !== 1'b1) begin bad++;
        $display("FAIL retrig_c%0d: got %b want 1", k, oWR_LOAD); end
    end
    @(negedge iCLK);
    total++; if (oWR_LOAD !== 1'b0) begin bad++;
      $display("FAIL retrig_off: got %b want 0", oWR_LOAD); end
    ev(0, 1, 0);
    idle(4);
    ev(0, 1, 0);
    total++; if ({oWR_BANK, oWR_LOAD, oDROP_CNT} !== {2'd0, 1'b0, 16'd1}) begin bad++;
      $display("FAIL orphan_end: wb=%0d load=%b drop=%0d want 0 0 1", oWR_BANK, oWR_LOAD, oDROP_CNT); end
    ev(1, 0, 0);
    ev(0, 1, 0);
    total++; if ({oWR_BANK, oWR_LOAD, oDROP_CNT} !== {2'd1, 1'b1, 16'd2}) begin bad++;
      $display("FAIL pre_rst: wb=%0d load=%b drop=%0d want 1 1 2", oWR_BANK, oWR_LOAD, oDROP_CNT); end
    iRST_N = 0;
    #1;
    total++; if ({oWR_LOAD, oRD_LOAD, oWR_BANK, oRD_BANK, oDROP_CNT} !== {2'b00, 2'd0, 2'd1, 16'd0}) begin bad++;
      $display("FAIL midrst_state: load=%b%b wb=%0d rb=%0d drop=%0d want 00 0 1 0",
               oWR_LOAD, oRD_LOAD, oWR_BANK, oRD_BANK, oDROP_CNT); end
    total++; if ({oWR_ADDR, oWR_MAX_ADDR, oRD_ADDR, oRD_MAX_ADDR} !== {22'h000000, 22'h04B000, 22'h100000, 22'h14B000}) begin bad++;
      $display("FAIL midrst_addr: %h %h %h %h want 000000 04b000 100000 14b000",
               oWR_ADDR, oWR_MAX_ADDR, oRD_ADDR, oRD_MAX_ADDR); end
    @(negedge iCLK);
    iRST_N = 1;
    @(negedge iCLK);
    total++; if ({oWR_LOAD, oRD_LOAD} !== 2'b11) begin bad++;
      $display("FAIL midrst_init: load=%b%b want 11", oWR_LOAD, oRD_LOAD); end
    idle(4);
  endtask

  initial begin
    #2;
    test_reset();
    test_basic();
    test_drops();
    test_simul();
    test_freeze();
    test_abort_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
